// File: rtl/mult_div_pkg.sv
// ============================================================================
// Module      : mult_div_pkg
// Description : Shared state encoding and iteration constants for mult_div_unit
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_div_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MULT = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } md_state_t;

  localparam int MD_ITER = 32;
  localparam int CNT_W   = 6;

endpackage

`default_nettype wire

// File: rtl/mult_div_unit_booth_step.sv
// ============================================================================
// Module      : booth_step
// Description : One radix-2 Booth iteration on the {upper, multiplier, q-1}
//               accumulator: add/sub/none of the multiplicand, then ASR by 1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] i_acc,
  input  logic [WIDTH-1:0] i_m,
  output logic [2*WIDTH:0] o_acc
);

  logic [WIDTH:0] w_upper;
  logic [WIDTH:0] w_m;
  logic [WIDTH:0] w_sum;

  // The add is done one bit wider so a most-negative multiplicand cannot
  // overflow the upper word; the extra bit becomes the shifted-in sign.
  assign w_upper = {i_acc[2*WIDTH], i_acc[2*WIDTH:WIDTH+1]};
  assign w_m     = {i_m[WIDTH-1], i_m};

  always_comb begin
    w_sum = w_upper;
    case (i_acc[1:0])
      2'b01:   w_sum = w_upper + w_m;
      2'b10:   w_sum = w_upper - w_m;
      default: w_sum = w_upper;
    endcase
  end

  assign o_acc = {w_sum, i_acc[WIDTH:1]};

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative signed Booth multiply / restoring divide with Hi/Lo.
//               Optional macro MULT_DIV_DZERO_EN enables the zero-divisor trap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

`ifdef MULT_DIV_DZERO_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  md_state_t        r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_div_zero;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opb;
  logic [2*WIDTH:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;

  logic [2*WIDTH:0] w_booth;
  logic [2*WIDTH:0] w_div_next;
  logic [WIDTH:0]   w_rsh;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic             w_last;
  logic             w_dz;

  booth_step #(.WIDTH(WIDTH)) u_booth (
    .i_acc (r_acc),
    .i_m   (r_opb),
    .o_acc (w_booth)
  );

  assign w_abs_a = op_a[WIDTH-1] ? -op_a : op_a;
  assign w_abs_b = op_b[WIDTH-1] ? -op_b : op_b;
  assign w_last  = (r_cnt == CNT_W'(MD_ITER - 1));
  assign w_dz    = DZ_EN && (op_b == '0);

  // Divide reuses the accumulator as {0, remainder, quotient/dividend}.
  assign w_rsh      = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_sub      = w_rsh - {1'b0, r_opb};
  assign w_div_next = w_sub[WIDTH] ? {1'b0, w_rsh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                   : {1'b0, w_sub[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_opb      <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (mult_start) begin
            r_state <= S_MULT;
            r_busy  <= 1'b1;
            r_acc   <= {WIDTH'(0), op_b, 1'b0};
            r_opb   <= op_a;
          end else if (div_start) begin
            r_div_zero <= w_dz;
            if (w_dz) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_DIV;
              r_busy  <= 1'b1;
              r_acc   <= {1'b0, WIDTH'(0), w_abs_a};
              r_opb   <= w_abs_b;
              r_neg_q <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
              r_neg_r <= op_a[WIDTH-1];
            end
          end
        end
        S_MULT: begin
          r_acc <= w_booth;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_hi    <= w_booth[2*WIDTH:WIDTH+1];
            r_lo    <= w_booth[WIDTH:1];
          end
        end
        S_DIV: begin
          r_acc <= w_div_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) r_state <= S_FIX;
        end
        S_FIX: begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_hi    <= r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
          r_lo    <= r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign div_zero = r_div_zero;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Scoreboard bench for mult_div_unit (either MULT_DIV_DZERO_EN build)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mult_start = 1'b0;
  logic        div_start = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .mult_start(mult_start), .div_start(div_start),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] prev_hi = '0;
  logic [31:0] prev_lo = '0;
  logic        prev_dz = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;

  // Called at a negedge: drives a start, pushes the expected result, returns after the accepting edge.
  task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint pa, pb, pr;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    if (m) begin
      pr = pa * pb;
      e.hi = pr[63:32]; e.lo = pr[31:0]; e.dz = prev_dz; e.lat = 33;
    end else if (b == 32'd0) begin
`ifdef MULT_DIV_DZERO_EN
      e.hi = prev_hi; e.lo = prev_lo; e.dz = 1'b1; e.lat = 1;
`else
      e.hi = a; e.lo = a[31] ? 32'h1 : 32'hFFFF_FFFF; e.dz = 1'b0; e.lat = 34;
`endif
    end else begin
      pr = pa / pb; e.lo = pr[31:0];
      pr = pa % pb; e.hi = pr[31:0];
      e.dz = 1'b0; e.lat = 34;
    end
    sb.push_back(e);
    mult_start = m; div_start = d; op_a = a; op_b = b;
    @(posedge clk);
    #1;
    mult_start = 1'b0; div_start = 1'b0;
    op_a = $urandom; op_b = $urandom;
  endtask

  // Waits (bounded) for done; counts protocol errors seen along the way.
  task automatic collect(input int k0, input logic [31:0] h0, input logic [31:0] l0,
                         output logic [31:0] ho, output logic [31:0] lw, output logic dzo,
                         output int cyc, output int err);
    cyc = -1; err = 0; ho = '0; lw = '0; dzo = 1'b0;
    for (int k = k0 + 1; k <= k0 + 60; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = k; ho = hi; lw = lo; dzo = div_zero;
        if (busy !== 1'b0) err++;
        break;
      end
      if (busy !== 1'b1 || hi !== h0 || lo !== l0) err++;
    end
    if (cyc >= 0) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) err++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_checks++; if ({hi, lo} !== 64'd0) $display("FAIL reset_hilo got %h want 0", {hi, lo}); else n_pass++;
    n_checks++; if (div_zero !== 1'b0) $display("FAIL reset_dz got %b want 0", div_zero); else n_pass++;
  endtask

  task automatic test_mult();
    logic [31:0] ta[6];
    logic [31:0] tb[6];
    logic [31:0] ho, lw;
    logic        dzo;
    int          cyc, err;
    exp_t        e;
    ta = '{32'd7, 32'h7FFF_FFFF, 32'h8000_0000, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF};
    tb = '{32'hFFFF_FFFD, 32'h7FFF_FFFF, 32'h8000_0000, 32'h9ABC_DEF0, 32'd5, 32'hFFFF_FFFF};
    for (int i = 0; i < 6; i++) begin
      issue(1'b1, 1'b0, ta[i], tb[i]);
      collect(0, prev_hi, prev_lo, ho, lw, dzo, cyc, err);
      e = sb.pop_front();
      n_checks++; if (cyc != e.lat) $display("FAIL mult%0d_latency got %0d want %0d", i, cyc, e.lat); else n_pass++;
      n_checks++; if (ho !== e.hi) $display("FAIL mult%0d_hi got %h want %h", i, ho, e.hi); else n_pass++;
      n_checks++; if (lw !== e.lo) $display("FAIL mult%0d_lo got %h want %h", i, lw, e.lo); else n_pass++;
      n_checks++; if (err != 0) $display("FAIL mult%0d_protocol got %0d errors want 0", i, err); else n_pass++;
      prev_hi = e.hi; prev_lo = e.lo; prev_dz = e.dz;
    end
  endtask

  task automatic test_div();
    logic [31:0] ta[6];
    logic [31:0] tb[6];
    logic [31:0] ho, lw;
    logic        dzo;
    int          cyc, err;
    exp_t        e;
    ta = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'hFFFF_FF9C, 32'd100, 32'd5};
    tb = '{32'd2, 32'd7, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFF9, 32'd10};
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, 1'b1, ta[i], tb[i]);
      collect(0, prev_hi, prev_lo, ho, lw, dzo, cyc, err);
      e = sb.pop_front();
      n_checks++; if (cyc != e.lat) $display("FAIL div%0d_latency got %0d want %0d", i, cyc, e.lat); else n_pass++;
      n_checks++; if (ho !== e.hi) $display("FAIL div%0d_hi got %h want %h", i, ho, e.hi); else n_pass++;
      n_checks++; if (lw !== e.lo) $display("FAIL div%0d_lo got %h want %h", i, lw, e.lo); else n_pass++;
      n_checks++; if (dzo !== e.dz || err != 0) $display("FAIL div%0d_dz_protocol got dz=%b err=%0d want dz=%b err=0", i, dzo, err, e.dz); else n_pass++;
      prev_hi = e.hi; prev_lo = e.lo; prev_dz = e.dz;
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] ta[2];
    logic [31:0] tb[2];
    logic [31:0] ho, lw;
    logic        dzo;
    int          cyc, err;
    exp_t        e;
    ta = '{32'h1234_5678, 32'd100};
    tb = '{32'd0, 32'd7};
    for (int i = 0; i < 2; i++) begin
      issue(1'b0, 1'b1, ta[i], tb[i]);
      collect(0, prev_hi, prev_lo, ho, lw, dzo, cyc, err);
      e = sb.pop_front();
      n_checks++; if (cyc != e.lat) $display("FAIL dz%0d_latency got %0d want %0d", i, cyc, e.lat); else n_pass++;
      n_checks++; if (ho !== e.hi || lw !== e.lo) $display("FAIL dz%0d_hilo got %h_%h want %h_%h", i, ho, lw, e.hi, e.lo); else n_pass++;
      n_checks++; if (dzo !== e.dz) $display("FAIL dz%0d_flag got %b want %b", i, dzo, e.dz); else n_pass++;
      n_checks++; if (err != 0) $display("FAIL dz%0d_protocol got %0d errors want 0", i, err); else n_pass++;
      prev_hi = e.hi; prev_lo = e.lo; prev_dz = e.dz;
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] ho, lw;
    logic        dzo;
    int          cyc, err, extra;
    exp_t        e;
    issue(1'b1, 1'b1, 32'd3, 32'd5);
    repeat (9) @(posedge clk);
    #1 div_start = 1'b1;
    @(posedge clk);
    #1 div_start = 1'b0;
    collect(10, prev_hi, prev_lo, ho, lw, dzo, cyc, err);
    e = sb.pop_front();
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    n_checks++; if (cyc != e.lat) $display("FAIL both_latency got %0d want %0d", cyc, e.lat); else n_pass++;
    n_checks++; if (ho !== e.hi || lw !== e.lo) $display("FAIL both_result got %h_%h want %h_%h", ho, lw, e.hi, e.lo); else n_pass++;
    n_checks++; if (extra != 0 || err != 0) $display("FAIL both_extra_done got %0d dones %0d errors want 0", extra, err); else n_pass++;
    prev_hi = e.hi; prev_lo = e.lo; prev_dz = e.dz;
  endtask

  task automatic test_reset_midop();
    logic [31:0] ho, lw;
    logic        dzo;
    int          cyc, err, extra;
    exp_t        e;
    issue(1'b1, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    prev_hi = '0; prev_lo = '0; prev_dz = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL midrst_ctrl got busy=%b done=%b want 0 0", busy, done); else n_pass++;
    n_checks++; if ({hi, lo} !== 64'd0) $display("FAIL midrst_hilo got %h want 0", {hi, lo}); else n_pass++;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    n_checks++; if (extra != 0) $display("FAIL midrst_no_done got %0d want 0", extra); else n_pass++;
    issue(1'b1, 1'b0, 32'd6, 32'hFFFF_FFF9);
    collect(0, prev_hi, prev_lo, ho, lw, dzo, cyc, err);
    e = sb.pop_front();
    n_checks++; if (cyc != e.lat || err != 0) $display("FAIL midrst_fresh_timing got %0d err %0d want %0d err 0", cyc, err, e.lat); else n_pass++;
    n_checks++; if (ho !== e.hi || lw !== e.lo) $display("FAIL midrst_fresh_result got %h_%h want %h_%h", ho, lw, e.hi, e.lo); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_simultaneous();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative signed multiply/divide unit for the multicycle MIPS datapath. It sits directly downstream of the control unit. It consumes the control unit's `MULT_on` and `DIV_on` pulses together with the A/B register values. It produces the 64-bit result in its internal Hi/Lo registers, which the datapath reads for `mfhi` and `mflo`. It signals completion so the control unit can leave its wait state.

## Interface
Parameters:
- `WIDTH`, 32: operand width; Hi and Lo are each `WIDTH` bits.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mult_start`  in  1  start a signed multiply; driven by `MULT_on`.
- `div_start`  in  1  start a signed divide; driven by `DIV_on`.
- `op_a`  in  WIDTH  multiplicand or dividend (register A).
- `op_b`  in  WIDTH  multiplier or divisor (register B).
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse when `hi`/`lo` hold the new result.
- `hi`  out  WIDTH  multiply: upper product word; divide: remainder.
- `lo`  out  WIDTH  multiply: lower product word; divide: quotient.
- `div_zero`  out  1  divisor was zero; feeds the control unit's `dzero` exception path.

## Operation
- States: IDLE, MULT, DIV, FIX, DONE.
- Reset values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, `div_zero`=0, iteration counter=0.

Starting an operation:
- A start is accepted only in IDLE. `op_a` and `op_b` are latched on the accepting edge; later changes to them have no effect.
- If `mult_start` and `div_start` arrive together, multiply wins and the divide request is dropped.
- Starts that arrive in MULT, DIV, FIX or DONE are ignored, not queued.

Multiply (MULT):
- Radix-2 Booth algorithm, signed, `WIDTH` iterations.
- 65-bit accumulator with an arithmetic right shift each step.
- After the last iteration the state goes to DONE, and `hi`/`lo` take the signed 64-bit product.

Divide (DIV):
- Restoring division on operand magnitudes, `WIDTH` iterations, then FIX.

Sign correction (FIX):
- Quotient is negated if the operand signs differ, so it truncates toward zero.
- Remainder takes the sign of the dividend.
- Then the state goes to DONE.
- 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000 and `hi`=0 (wraps; no flag).

DONE:
- `done`=1 for exactly one cycle, then the state returns to IDLE.
- `busy`=1 in MULT, DIV and FIX; 0 in IDLE and DONE.

Holding and clearing:
- `hi` and `lo` hold the last result until the next DONE or a reset; they never show intermediate values.
- `div_zero` is updated only when a divide is accepted and holds until the next accepted divide.

## Timing
Let cycle 0 be the cycle in which the start is sampled high in IDLE.
- Multiply: `done` high in cycle 33; `hi`/`lo` valid from cycle 33.
- Divide: `done` high in cycle 34 (32 iterations, FIX in cycle 33).
- A new start is accepted no earlier than the cycle after `done`.
- Reset in any cycle: outputs return to reset values on that edge, and any operation in flight is abandoned with no `done`.

## Configuration
Macro `MULT_DIV_DZERO_EN`.

Defined:
- A divide with `op_b`==0 goes from IDLE straight to DONE.
- `done` and `div_zero` are both high in cycle 1.
- `hi`/`lo` keep their previous values.

Undefined:
- No zero check; `div_zero` is tied 0.
- The divide runs the normal 34 cycles and yields `lo`=0xFFFFFFFF and `hi`=|dividend|, then sign correction (dividend sign only).

## Structure
- Shared package `mult_div_pkg`:
  - state enum (IDLE, MULT, DIV, FIX, DONE);
  - `MD_ITER` = 32;
  - counter width = 6.
- One natural sub-module: `booth_step`, the combinational single Booth iteration (add/sub/none plus arithmetic shift of the 65-bit accumulator).
- Restoring division, the counter and the FSM live in the top module.

## Test plan
- Multiply 7 × 0xFFFFFFFD (−3) -> `done` in cycle 33, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB, `busy` high in cycles 1–32.
- Multiply 0x7FFFFFFF × 0x7FFFFFFF -> `hi`=0x3FFFFFFF, `lo`=0x00000001.
- Divide 0xFFFFFFF9 (−7) ÷ 2 -> `done` in cycle 34, `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF; then 100 ÷ 7 -> `lo`=14, `hi`=2.
- Divide 0x12345678 ÷ 0:
  - with `MULT_DIV_DZERO_EN`: `done` and `div_zero` high in cycle 1, `hi`/`lo` unchanged;
  - without it: `done` in cycle 34, `lo`=0xFFFFFFFF, `hi`=0x12345678, `div_zero`=0.
- `mult_start` and `div_start` together with 3, 5 -> multiply only, `lo`=15, `hi`=0; a second `div_start` pulsed in cycle 10 is ignored (single `done`).
- Reset asserted in cycle 10 of a multiply -> `busy`=0, `hi`=`lo`=0 next cycle, no `done`; a fresh start afterwards completes normally.
